// File: rtl/tea_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one TEA core between N_REQ requesters; it drives the core register bus.
// Optional key cache (skip key writes when the key is unchanged): define TEA_ARB_KEY_CACHE_EN.
module tea_arbiter #(
   parameter int                   WORD_SIZE = 32,
   parameter int                   N_REQ     = 2,
   parameter logic [WORD_SIZE-1:0] CTRL_ENC  = WORD_SIZE'(1),
   parameter logic [WORD_SIZE-1:0] CTRL_DEC  = WORD_SIZE'(3)
) (
   input  logic                         i_clk,
   input  logic                         i_rstn,
   input  logic [N_REQ-1:0]             i_req,
   input  logic [N_REQ-1:0]             i_op,
   input  logic [N_REQ*2*WORD_SIZE-1:0] i_block,
   input  logic [N_REQ*4*WORD_SIZE-1:0] i_key,
   output logic [N_REQ-1:0]             o_gnt,
   output logic [N_REQ-1:0]             o_done,
   output logic [2*WORD_SIZE-1:0]       o_result,
   output logic [WORD_SIZE-1:0]         o_tea_data,
   output logic [3:0]                   o_tea_addr,
   output logic                         o_tea_we,
   input  logic [WORD_SIZE-1:0]         i_tea_data,
   input  logic                         i_tea_ready
);
   localparam int W  = WORD_SIZE;
   localparam int PW = $clog2(N_REQ);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_GUARD, S_WAIT, S_RD0, S_RD1, S_RD2, S_DONE
   } state_t;

   state_t           state;
   logic [2:0]       idx;
   logic             guard_cnt;
   logic [PW-1:0]    gnt_idx;
   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    sel;
   logic             found;
   logic [PW:0]      cand;
   logic             op_q;
   logic [2*W-1:0]   blk_q;
   logic [4*W-1:0]   key_q;
   logic [W-1:0]     res_lo;
`ifdef TEA_ARB_KEY_CACHE_EN
   logic [4*W-1:0]   key_cache;
   logic             key_vld;
   logic             key_hit;
`endif

   function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] i);
      logic [N_REQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Register-bus word for write address a: v0, v1, k0..k3, then the control code.
   function automatic logic [W-1:0] load_word(input logic [2:0] a, input logic [2*W-1:0] blk,
                                              input logic [4*W-1:0] key, input logic op);
      case (a)
         3'd0:    return blk[W-1:0];
         3'd1:    return blk[2*W-1:W];
         3'd2:    return key[W-1:0];
         3'd3:    return key[2*W-1:W];
         3'd4:    return key[3*W-1:2*W];
         3'd5:    return key[4*W-1:3*W];
         default: return op ? CTRL_DEC : CTRL_ENC;
      endcase
   endfunction

   // First requesting index at or after rr_ptr, wrapping.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = {1'b0, rr_ptr} + (PW+1)'(i);
         if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
         if (!found && i_req[cand[PW-1:0]]) begin
            found = 1'b1;
            sel   = cand[PW-1:0];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (state == S_IDLE && found) begin
         op_q  <= i_op[sel];
         blk_q <= i_block[sel*2*W +: 2*W];
         key_q <= i_key[sel*4*W +: 4*W];
      end
      if (state == S_RD1) res_lo <= i_tea_data;
   end

`ifdef TEA_ARB_KEY_CACHE_EN
   always_ff @(posedge i_clk)
      if (state == S_LOAD && idx == 3'd5) key_cache <= key_q;
`endif

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state      <= S_IDLE;
         idx        <= '0;
         guard_cnt  <= 1'b0;
         gnt_idx    <= '0;
         rr_ptr     <= '0;
         o_gnt      <= '0;
         o_done     <= '0;
         o_result   <= '0;
         o_tea_we   <= 1'b0;
         o_tea_addr <= '0;
         o_tea_data <= '0;
`ifdef TEA_ARB_KEY_CACHE_EN
         key_vld    <= 1'b0;
         key_hit    <= 1'b0;
`endif
      end else begin
         o_done <= '0;
         case (state)
            S_IDLE: if (found) begin
               state   <= S_LOAD;
               gnt_idx <= sel;
               o_gnt   <= onehot(sel);
               idx     <= '0;
`ifdef TEA_ARB_KEY_CACHE_EN
               key_hit <= key_vld && (i_key[sel*4*W +: 4*W] == key_cache);
`endif
            end
            S_LOAD: begin
               o_tea_we   <= 1'b1;
               o_tea_addr <= {1'b0, idx};
               o_tea_data <= load_word(idx, blk_q, key_q, op_q);
               if (idx == 3'd6) begin
                  state     <= S_GUARD;
                  guard_cnt <= 1'b0;
`ifdef TEA_ARB_KEY_CACHE_EN
                  key_vld   <= 1'b1;
`endif
               end
`ifdef TEA_ARB_KEY_CACHE_EN
               else if (key_hit && idx == 3'd1) idx <= 3'd6;
`endif
               else idx <= idx + 3'd1;
            end
            // Core keeps reporting ready until its FSM leaves idle, so ready is not looked at here.
            S_GUARD: begin
               o_tea_we   <= 1'b0;
               o_tea_data <= '0;
               o_tea_addr <= 4'd7;
               guard_cnt  <= 1'b1;
               if (guard_cnt) state <= S_WAIT;
            end
            S_WAIT: if (i_tea_ready) state <= S_RD0;
            S_RD0: begin
               o_tea_addr <= 4'd8;
               state      <= S_RD1;
            end
            S_RD1: begin
               o_tea_addr <= 4'd0;
               state      <= S_RD2;
            end
            S_RD2: begin
               o_result <= {i_tea_data, res_lo};
               o_done   <= onehot(gnt_idx);
               state    <= S_DONE;
            end
            S_DONE: begin
               o_gnt  <= '0;
               rr_ptr <= (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + PW'(1);
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tea_arbiter.sv
`timescale 1ns/1ps
// Bench for tea_arbiter: stub TEA core on the register bus, scoreboard queue checked by a monitor.
module tb_tea_arbiter;
   localparam int          N     = 2;
   localparam logic [31:0] C_ENC = 32'h1;
   localparam logic [31:0] C_DEC = 32'h3;
   localparam logic [63:0] ENC0  = 64'h94BAA940_41EA3A0A;
   localparam logic [127:0] K1   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
   localparam logic [63:0] B1    = 64'hDEADBEEF_CAFEF00D;
`ifdef TEA_ARB_KEY_CACHE_EN
   localparam bit CACHE_EN = 1'b1;
`else
   localparam bit CACHE_EN = 1'b0;
`endif

   logic             clk;
   logic             rstn;
   logic [N-1:0]     req, op, gnt, done;
   logic [N*64-1:0]  blk;
   logic [N*128-1:0] key;
   logic [63:0]      result;
   logic [31:0]      tea_data, core_rd;
   logic [3:0]       tea_addr;
   logic             tea_we, core_ready;

   tea_arbiter #(.WORD_SIZE(32), .N_REQ(N), .CTRL_ENC(C_ENC), .CTRL_DEC(C_DEC)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_op(op), .i_block(blk), .i_key(key),
      .o_gnt(gnt), .o_done(done), .o_result(result), .o_tea_data(tea_data),
      .o_tea_addr(tea_addr), .o_tea_we(tea_we), .i_tea_data(core_rd), .i_tea_ready(core_ready));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] tea_model(input logic [63:0] b, input logic [127:0] k, input bit dec);
      logic [31:0] v0, v1, s, k0, k1, k2, k3;
      v0 = b[31:0]; v1 = b[63:32];
      k0 = k[31:0]; k1 = k[63:32]; k2 = k[95:64]; k3 = k[127:96];
      s  = dec ? 32'hC6EF3720 : 32'h0;
      for (int i = 0; i < 32; i++) begin
         if (!dec) begin
            s  = s + 32'h9E3779B9;
            v0 = v0 + (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
            v1 = v1 + (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
         end else begin
            v1 = v1 - (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
            v0 = v0 - (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
            s  = s - 32'h9E3779B9;
         end
      end
      return {v1, v0};
   endfunction

   // Stub core: ready stays high stub_hold cycles after the control write, results appear after stub_busy.
   logic [31:0] sregs [0:6];
   logic [63:0] sres;
   logic        sact, s_done;
   int          st;
   int          stub_hold = 1, stub_busy = 33;
   assign s_done     = !sact || (st >= stub_busy);
   assign core_ready = !sact || (st < stub_hold) || (st >= stub_busy);

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sact    <= 1'b0;
         st      <= 0;
         sres    <= '0;
         core_rd <= '0;
         for (int i = 0; i < 7; i++) sregs[i] <= '0;
      end else begin
         if (tea_addr == 4'd7)      core_rd <= s_done ? sres[31:0]  : 32'hDEAD0000;
         else if (tea_addr == 4'd8) core_rd <= s_done ? sres[63:32] : 32'hDEAD0001;
         else                       core_rd <= '0;
         if (sact && st < stub_busy) st <= st + 1;
         if (tea_we) begin
            if (tea_addr < 4'd7) sregs[tea_addr[2:0]] <= tea_data;
            if (tea_addr == 4'd6) begin
               sres <= tea_model({sregs[1], sregs[0]}, {sregs[5], sregs[4], sregs[3], sregs[2]},
                                 tea_data == C_DEC);
               sact <= 1'b1;
               st   <= 0;
            end
         end
      end
   end

   typedef struct {
      int          req;
      logic [63:0] res;
      int          writes;
      logic [31:0] ctrl;
      int          gap;
   } exp_t;
   exp_t exp_q[$];

   // Monitor: per-operation bus bookkeeping, compared against the queue head on each done pulse.
   initial begin : monitor
      int wcnt, first_addr, last_addr, t6, gap_m;
      logic [31:0] last_data;
      bit gnt_bad, bus_bad;
      logic [N-1:0] oh;
      exp_t e;
      wcnt = 0; first_addr = -1; last_addr = -1; t6 = -1; gap_m = -1;
      last_data = '0; gnt_bad = 0; bus_bad = 0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            wcnt = 0; first_addr = -1; last_addr = -1; t6 = -1; gap_m = -1;
            last_data = '0; gnt_bad = 0; bus_bad = 0;
            continue;
         end
         if (gnt != '0) begin
            if ($countones(gnt) != 1) gnt_bad = 1;
            if (exp_q.size() > 0) begin
               oh = '0; oh[exp_q[0].req] = 1'b1;
               if (gnt != oh) gnt_bad = 1;
            end
         end
         if (!tea_we && tea_data != '0) bus_bad = 1;
         if (tea_we && gnt == '0) bus_bad = 1;
         if (tea_we) begin
            wcnt++;
            if (wcnt == 1) first_addr = int'(tea_addr);
            last_addr = int'(tea_addr);
            last_data = tea_data;
            if (tea_addr == 4'd6) begin t6 = cyc; gap_m = -1; end
         end
         if (tea_addr == 4'd8 && gap_m < 0 && t6 >= 0) gap_m = cyc - t6;
         if (done != '0) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_done: got %b with empty queue", done);
            end else begin
               e = exp_q.pop_front();
               oh = '0; oh[e.req] = 1'b1;
               chk($sformatf("done_idx r%0d", e.req), 64'(done), 64'(oh));
               chk($sformatf("result r%0d", e.req), result, e.res);
               chk($sformatf("write_count r%0d", e.req), 64'(wcnt), 64'(e.writes));
               chk("first_write_addr", 64'(first_addr), 64'd0);
               chk("last_write_addr", 64'(last_addr), 64'd6);
               chk("ctrl_word", 64'(last_data), 64'(e.ctrl));
               chk("gnt_onehot_owner", 64'(gnt_bad), 64'd0);
               chk("bus_idle_zero", 64'(bus_bad), 64'd0);
               if (e.gap >= 0) chk("ctrl_to_rd1_gap", 64'(gap_m), 64'(e.gap));
            end
            wcnt = 0; first_addr = -1; last_addr = -1; t6 = -1; gap_m = -1;
            last_data = '0; gnt_bad = 0; bus_bad = 0;
         end
      end
   end

   logic [127:0] bc_key;
   bit           bc_vld;

   task automatic issue(input int r, input bit o, input logic [63:0] b, input logic [127:0] k,
                        input logic [63:0] res, input int gap);
      exp_t e;
      op[r] = o;
      blk[r*64 +: 64] = b;
      key[r*128 +: 128] = k;
      e.req = r; e.res = res; e.ctrl = o ? C_DEC : C_ENC; e.gap = gap;
      e.writes = (CACHE_EN && bc_vld && bc_key == k) ? 3 : 7;
      bc_key = k; bc_vld = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input logic [N-1:0] mask, input string nm);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if ((done & mask) != '0) return;
      end
      n_cmp++; n_bad++;
      $display("FAIL timeout_%s: no done after 300 cycles, required one", nm);
   endtask

   task automatic wait_gnt(input logic [N-1:0] mask, input string nm);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if ((gnt & mask) != '0) return;
      end
      n_cmp++; n_bad++;
      $display("FAIL timeout_%s: no grant after 50 cycles, required one", nm);
   endtask

   task automatic wait_ctrl(input string nm);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tea_we && tea_addr == 4'd6) return;
      end
      n_cmp++; n_bad++;
      $display("FAIL timeout_%s: no control write after 50 cycles, required one", nm);
   endtask

   initial begin : stim
      logic [63:0] c1;
      rstn = 1'b0; req = '0; op = '0; blk = '0; key = '0; bc_key = '0; bc_vld = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_we", 64'(tea_we), 64'd0);
      chk("rst_addr", 64'(tea_addr), 64'd0);
      chk("rst_data", 64'(tea_data), 64'd0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // single encrypt; operands changed after grant must not matter
      issue(0, 1'b0, 64'd0, 128'd0, ENC0, -1);
      req[0] = 1'b1;
      wait_gnt(2'b01, "gnt0");
      blk[63:0] = 64'hFFFF_FFFF_FFFF_FFFF; op[0] = 1'b1; key[127:0] = '1;
      wait_done(2'b01, "enc0");
      req[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("result_hold", result, ENC0);

      // decrypt round trip on requester 1
      issue(1, 1'b1, ENC0, 128'd0, 64'd0, -1);
      req[1] = 1'b1;
      wait_done(2'b10, "dec1");
      req[1] = 1'b0;
      repeat (2) @(negedge clk);

      // contention: both held, grants must alternate 0,1,0,1
      for (int i = 0; i < 2; i++) begin
         issue(0, 1'b0, 64'd0, 128'd0, ENC0, -1);
         issue(1, 1'b1, ENC0, 128'd0, 64'd0, -1);
      end
      req = 2'b11;
      for (int i = 0; i < 4; i++) wait_done(2'b11, "contention");
      req = '0;
      repeat (2) @(negedge clk);

      // guard: ready held high after the control write
      stub_hold = 5; stub_busy = 0;
      issue(0, 1'b0, 64'd0, 128'd0, ENC0, 4);
      req[0] = 1'b1;
      wait_done(2'b01, "guard");
      req[0] = 1'b0;
      stub_hold = 1; stub_busy = 33;
      repeat (2) @(negedge clk);

      // reset while waiting for the core
      op[1] = 1'b0; blk[127:64] = '0; key[255:128] = '0;
      req[1] = 1'b1;
      wait_ctrl("abort_op");
      repeat (5) @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("arst_gnt", 64'(gnt), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_result", result, 64'd0);
      chk("arst_we", 64'(tea_we), 64'd0);
      chk("arst_addr", 64'(tea_addr), 64'd0);
      chk("arst_data", 64'(tea_data), 64'd0);
      exp_q.delete();
      bc_vld = 1'b0;
      req = '0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // pointer restarts at 0 after reset
      issue(0, 1'b0, 64'd0, 128'd0, ENC0, -1);
      issue(1, 1'b1, ENC0, 128'd0, 64'd0, -1);
      req = 2'b11;
      for (int i = 0; i < 2; i++) wait_done(2'b11, "post_reset");
      req = '0;
      repeat (2) @(negedge clk);

      // same key twice, then a new key and its round trip
      for (int i = 0; i < 2; i++) begin
         issue(0, 1'b0, 64'd0, 128'd0, ENC0, -1);
         req[0] = 1'b1;
         wait_done(2'b01, "same_key");
         req[0] = 1'b0;
         @(negedge clk);
      end
      c1 = tea_model(B1, K1, 1'b0);
      issue(0, 1'b0, B1, K1, c1, -1);
      req[0] = 1'b1;
      wait_done(2'b01, "new_key");
      req[0] = 1'b0;
      @(negedge clk);
      issue(1, 1'b1, c1, K1, B1, -1);
      req[1] = 1'b1;
      wait_done(2'b10, "new_key_dec");
      req[1] = 1'b0;
      repeat (4) @(negedge clk);

      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/tea_arbiter.md
# tea_arbiter

Round-robin scheduler that shares one `tea` core between `N_REQ` requesters. It sequences the core's register bus: it writes the data words, key words and control word, waits for completion, then reads both result words. Each winning requester receives one encrypt/decrypt result and a done pulse. It sits between the client logic and the single `tea` instance and is the only master on that core's `i_data/i_addr/i_we` bus.

## Interface
- `WORD_SIZE`, 32, width of one TEA half-block/key word.
- `N_REQ`, 2, number of requesters (2..8).
- `i_clk`  in  1  clock; also clocks the `tea` core.
- `i_rstn`  in  1  asynchronous active-low reset.
- `i_req`  in  N_REQ  request per requester; held until its `o_done`.
- `i_op`  in  N_REQ  per requester: 0 = encrypt (`CTRL_ENC`), 1 = decrypt (`CTRL_DEC`).
- `i_block`  in  N_REQ*2*WORD_SIZE  requester r at `[r*2W +: 2W]`, v0 in the low word.
- `i_key`  in  N_REQ*4*WORD_SIZE  requester r at `[r*4W +: 4W]`, k0 in the low word.
- `o_gnt`  out  N_REQ  one-hot grant, high from grant until the `o_done` cycle inclusive.
- `o_done`  out  N_REQ  one-cycle pulse on the granted bit when `o_result` is valid.
- `o_result`  out  2*WORD_SIZE  {v1,v0} result; held until the next done.
- `o_tea_data`  out  WORD_SIZE  write data to core `i_data`.
- `o_tea_addr`  out  4  core `i_addr`.
- `o_tea_we`  out  1  core `i_we`.
- `i_tea_data`  in  WORD_SIZE  core `o_data` (registered, 1-cycle read latency).
- `i_tea_ready`  in  1  core `o_ready`.

## Operation
- States: IDLE, LOAD, GUARD, WAIT, RD0, RD1, RD2, DONE.
- IDLE: if any `i_req`, grant the first set index at or after `rr_ptr`, wrapping. Latch op/block/key into internal registers, assert `o_gnt`, go to LOAD. Arbitration happens only in IDLE.
- LOAD: one write per cycle with `o_tea_we`=1, addresses 0,1,2,3,4,5,6. Data is v0, v1, k0..k3, then the control code (`CTRL_ENC`/`CTRL_DEC` from `tea.svh`). A 3-bit index counts the writes. After address 6, go to GUARD.
- GUARD: 2 cycles during which `i_tea_ready` is ignored, because the core still reports ready until its FSM leaves IDLE. Then go to WAIT.
- WAIT: `o_tea_we`=0, `o_tea_addr`=7. Stay until `i_tea_ready`=1, then go to RD0.
- RD0: addr 7. RD1: addr 8; capture `i_tea_data` into `o_result[W-1:0]`. RD2: capture `i_tea_data` into `o_result[2W-1:W]`.
- DONE: pulse `o_done[g]`, drop `o_gnt` on the next cycle, set `rr_ptr` = (g+1) mod N_REQ, go to IDLE.
- Operands are latched at grant. Changes to `i_block`/`i_key`/`i_op` after grant have no effect.
- If `i_req[g]` drops mid-operation, the operation still completes and `o_done[g]` still pulses. The requester ignores the result.
- Outside LOAD, `o_tea_we`=0 and `o_tea_data`=0.
- Simultaneous requests: strictly round-robin. No requester waits more than N_REQ-1 operations.

## Timing
- All outputs are registered.
- Reset values: `o_gnt`=0, `o_done`=0, `o_result`=0, `o_tea_we`=0, `o_tea_addr`=0, `o_tea_data`=0, `rr_ptr`=0, state IDLE.
- Reset mid-operation aborts immediately. The core shares `i_rstn`, so both restart clean.
- Latency from `i_req` rise (sampled in IDLE) to `o_done`:
  - 1 (grant) + 7 (LOAD) + 2 (GUARD) + WAIT + 3 (RD) + 1 (DONE).
  - WAIT is about 33 cycles with the core's 32-round FSM, giving roughly 47 cycles total.
- Back-to-back: IDLE can grant again in the cycle after DONE.

## Configuration
- `TEA_ARB_KEY_CACHE_EN` defined: the block keeps the last key written to the core plus a valid bit, cleared by reset. In LOAD, key writes (addresses 2..5) are skipped when the latched key equals the cached key, so LOAD takes 3 cycles (addresses 0, 1, 6).
- `TEA_ARB_KEY_CACHE_EN` undefined: all 7 writes are always performed. No cache registers exist.

## Test plan
- Single encrypt: req0 alone, key=0, block {v1,v0}={0,0}, op=0.
  - `o_done[0]` pulses once; `o_result`={0x94BAA940,0x41EA3A0A}.
  - Exactly 7 writes at addresses 0..6, the last with data `CTRL_ENC`.
- Decrypt round-trip: req1, op=1, key=0, block={0x94BAA940,0x41EA3A0A}.
  - `o_result`={0,0}; `o_gnt`=2'b10 for the whole operation.
- Contention: req0 and req1 held high continuously.
  - Grants alternate 0,1,0,1 over 4 operations; `o_gnt` is never non-one-hot.
  - Each operation's result matches its requester's vector.
- Guard/ready: hold core `o_ready` high for 5 cycles after the control write (stubbed core).
  - No RD0 before GUARD expires; results are read only after ready is seen.
- Reset mid-operation: assert `i_rstn`=0 during WAIT.
  - All outputs are 0 asynchronously and the next request completes correctly.
- Key cache: with `TEA_ARB_KEY_CACHE_EN`, two encrypts with the same key=0.
  - The second operation performs 3 writes; the result is still correct.
  - Changing the key forces all 7 writes.
